// File: rtl/uart_pkg.sv
// Shared UART definitions: parity selectors, transmitter state encoding and
// the frame-length helper used by both the transmitter and the receiver.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef logic [2:0] tx_state_t;

  localparam tx_state_t ST_IDLE  = 3'd0;
  localparam tx_state_t ST_START = 3'd1;
  localparam tx_state_t ST_DATA  = 3'd2;
  localparam tx_state_t ST_PAR   = 3'd3;
  localparam tx_state_t ST_STOP  = 3'd4;
  localparam tx_state_t ST_BREAK = 3'd5;

  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Valid/ready word handshake into the UART transmitter.
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] in;
  logic                 in_valid;
  logic                 in_ready;

  modport master (output in, output in_valid, input in_ready);
  modport slave  (input in, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_hold.sv
// Single-entry holding register between the handshake and the shift register.
module uart_tx_hold #(
  parameter int DATA_BITS = 8
) (
  input  logic                 ref_clk,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] push_data_i,
  input  logic                 push_valid_i,
  output logic                 push_ready_o,
  input  logic                 pop_i,
  output logic                 full_o,
  output logic [DATA_BITS-1:0] data_o
);

  logic                 full_q, full_d;
  logic [DATA_BITS-1:0] data_q, data_d;

  assign push_ready_o = ~full_q;
  assign full_o       = full_q;
  assign data_o       = data_q;

  // NOTE: every variable is given its current value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (push_valid_i && !full_q) begin
      full_d = 1'b1;
      data_d = push_data_i;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
  end

  // NOTE: flops take non-blocking assignments so all registers update together from pre-edge values.
  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) full_q <= 1'b0;
    else          full_q <= full_d;
  end

  // NOTE: the data register carries no reset; full_q alone says whether its contents mean anything.
  always_ff @(posedge ref_clk) begin
    data_q <= data_d;
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, DATA_BITS data (LSB first), optional
// parity, 1-2 stop bits, plus line break; bit timing from the bit_clk strobe.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PARITY_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic           ref_clk,
  input  logic           reset_n,
  input  logic           bit_clk,
  uart_tx_frame_if.slave tx_if,
  input  logic           brk,
  output logic           busy,
  output logic           done,
  output logic           out
);

  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 par_q, par_d;
  logic                 out_q, out_d;
  logic                 done_q, done_d;
  logic                 load;
  logic                 hold_full;
  logic [DATA_BITS-1:0] hold_data;

  uart_tx_hold #(.DATA_BITS(DATA_BITS)) u_hold (
    .ref_clk      (ref_clk),
    .reset_n      (reset_n),
    .push_data_i  (tx_if.in),
    .push_valid_i (tx_if.in_valid),
    .push_ready_o (tx_if.in_ready),
    .pop_i        (load),
    .full_o       (hold_full),
    .data_o       (hold_data)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_d      = par_q;
    out_d      = out_q;
    done_d     = 1'b0;
    load       = 1'b0;
    if (bit_clk) begin
      case (state_q)
        ST_IDLE: begin
          if (brk) begin
            state_d = ST_BREAK;
            out_d   = 1'b0;
          end else if (hold_full) begin
            load = 1'b1;
          end else begin
            out_d = 1'b1;
          end
        end
        ST_START: begin
          state_d   = ST_DATA;
          out_d     = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
        end
        ST_DATA: begin
          if (bit_cnt_q == LAST_BIT) begin
            if (PARITY != PARITY_NONE) begin
              state_d = ST_PAR;
              out_d   = par_q;
            end else begin
              state_d    = ST_STOP;
              out_d      = 1'b1;
              stop_cnt_d = 1'b0;
            end
          end else begin
            out_d     = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        ST_PAR: begin
          state_d    = ST_STOP;
          out_d      = 1'b1;
          stop_cnt_d = 1'b0;
        end
        ST_STOP: begin
          if (stop_cnt_q == LAST_STOP) begin
            done_d = 1'b1;
            // A pending break wins over a queued word; a queued word starts with no mark gap.
            if (brk) begin
              state_d = ST_BREAK;
              out_d   = 1'b0;
            end else if (hold_full) begin
              load = 1'b1;
            end else begin
              state_d = ST_IDLE;
              out_d   = 1'b1;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
        ST_BREAK: begin
          if (!brk) begin
            state_d = ST_IDLE;
            out_d   = 1'b1;
          end else begin
            out_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          out_d   = 1'b1;
        end
      endcase
    end
    if (load) begin
      state_d = ST_START;
      out_d   = 1'b0;
      shift_d = hold_data;
      par_d   = (PARITY == PARITY_ODD) ? ~^hold_data : ^hold_data;
    end
  end

  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      out_q      <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      out_q      <= out_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge ref_clk) begin
    shift_q <= shift_d;
    par_q   <= par_d;
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign out  = out_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: three configurations, a bit-level
// scoreboard fed when words are offered and drained as the line is sampled.
module tb_uart_tx_frame;

  logic ref_clk = 1'b0;
  logic reset_n = 1'b0;
  logic bit_clk = 1'b0;
  logic brk_a = 1'b0, brk_b = 1'b0, brk_c = 1'b0;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;
  logic out_a, out_b, out_c;

  int  total = 0;
  int  bad   = 0;
  logic exp_q[$];
  time t_start, t_done;

  uart_tx_frame_if #(.DATA_BITS(8)) if_a ();
  uart_tx_frame_if #(.DATA_BITS(7)) if_b ();
  uart_tx_frame_if #(.DATA_BITS(8)) if_c ();

  uart_tx_frame #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .ref_clk(ref_clk), .reset_n(reset_n), .bit_clk(bit_clk), .tx_if(if_a.slave),
    .brk(brk_a), .busy(busy_a), .done(done_a), .out(out_a));
  uart_tx_frame #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
    .ref_clk(ref_clk), .reset_n(reset_n), .bit_clk(bit_clk), .tx_if(if_b.slave),
    .brk(brk_b), .busy(busy_b), .done(done_b), .out(out_b));
  uart_tx_frame #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_c (
    .ref_clk(ref_clk), .reset_n(reset_n), .bit_clk(bit_clk), .tx_if(if_c.slave),
    .brk(brk_c), .busy(busy_c), .done(done_c), .out(out_c));

  always #5 ref_clk = ~ref_clk;

  // bit_clk: one ref_clk cycle high out of every four, changed on the falling edge
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge ref_clk);
      bit_clk = (ph == 3);
      ph = (ph + 1) % 4;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  function automatic logic out_of(input int s);
    case (s)
      0: return out_a;
      1: return out_b;
      default: return out_c;
    endcase
  endfunction

  function automatic logic done_of(input int s);
    case (s)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic logic busy_of(input int s);
    case (s)
      0: return busy_a;
      1: return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic ready_of(input int s);
    case (s)
      0: return if_a.in_ready;
      1: return if_b.in_ready;
      default: return if_c.in_ready;
    endcase
  endfunction

  task automatic set_in(input int s, input logic [8:0] d, input logic v);
    case (s)
      0: begin if_a.in = d[7:0]; if_a.in_valid = v; end
      1: begin if_b.in = d[6:0]; if_b.in_valid = v; end
      default: begin if_c.in = d[7:0]; if_c.in_valid = v; end
    endcase
  endtask

  // Reference frame: start, data LSB first, parity from a ones count, stop bits.
  task automatic push_frame(input int dbits, input int par, input int sbits, input logic [8:0] d);
    int ones;
    ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < dbits; i++) begin
      exp_q.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (par == 1) exp_q.push_back((ones % 2) == 0);
    if (par == 2) exp_q.push_back((ones % 2) == 1);
    for (int i = 0; i < sbits; i++) exp_q.push_back(1'b1);
  endtask

  task automatic wait_bit_edge();
    do @(posedge ref_clk); while (bit_clk !== 1'b1);
    #1;
  endtask

  task automatic send(input int s, input logic [8:0] d, input bit keep_valid);
    int budget;
    budget = 400;
    @(negedge ref_clk);
    set_in(s, d, 1'b1);
    while (ready_of(s) !== 1'b1 && budget > 0) begin
      @(negedge ref_clk);
      budget--;
    end
    total++;
    if (budget == 0) begin
      bad++;
      $display("FAIL handshake dut=%0d got in_ready=%b want 1", s, ready_of(s));
    end
    @(posedge ref_clk);
    if (!keep_valid) begin
      @(negedge ref_clk);
      set_in(s, d, 1'b0);
    end
  endtask

  // Finds a start bit within max_wait bit periods, then checks every bit against the scoreboard.
  task automatic check_frames(input int s, input int n_frames, input int flen, input int max_wait,
                              input string name);
    int   waited;
    logic e;
    waited = 1;
    wait_bit_edge();
    while (out_of(s) !== 1'b0 && waited < max_wait) begin
      wait_bit_edge();
      waited++;
    end
    total++;
    if (out_of(s) !== 1'b0) begin
      bad++;
      $display("FAIL %s_start got out=%b want 0 within %0d bits", name, out_of(s), max_wait);
      return;
    end
    t_start = $time;
    for (int f = 0; f < n_frames; f++) begin
      for (int b = 0; b < flen; b++) begin
        if (f > 0 || b > 0) wait_bit_edge();
        total++;
        if (done_of(s) !== ((b == 0 && f > 0) ? 1'b1 : 1'b0)) begin
          bad++;
          $display("FAIL %s_done f%0d b%0d got=%b want=%b", name, f, b, done_of(s), (b == 0 && f > 0));
        end
        total++;
        if (busy_of(s) !== 1'b1) begin
          bad++;
          $display("FAIL %s_busy f%0d b%0d got=%b want=1", name, f, b, busy_of(s));
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
        total++;
        if (out_of(s) !== e) begin
          bad++;
          $display("FAIL %s_bit f%0d b%0d got=%b want=%b", name, f, b, out_of(s), e);
        end
      end
    end
    wait_bit_edge();
    t_done = $time;
    total++;
    if (done_of(s) !== 1'b1) begin
      bad++;
      $display("FAIL %s_done_end got=%b want=1", name, done_of(s));
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge ref_clk);
    for (int s = 0; s < 3; s++) begin
      total++;
      if ({out_of(s), ready_of(s), busy_of(s), done_of(s)} !== 4'b1100) begin
        bad++;
        $display("FAIL reset dut=%0d got out/rdy/busy/done=%b want 1100", s,
                 {out_of(s), ready_of(s), busy_of(s), done_of(s)});
      end
    end
    reset_n = 1'b1;
    repeat (2) @(negedge ref_clk);
  endtask

  task automatic test_8n1();
    push_frame(8, 0, 1, 9'h055);
    send(0, 9'h055, 1'b0);
    check_frames(0, 1, 10, 8, "8n1");
    total++;
    if (t_done - t_start !== 400) begin
      bad++;
      $display("FAIL 8n1_done_time got=%0t want=400", t_done - t_start);
    end
    total++;
    if (busy_a !== 1'b0) begin
      bad++;
      $display("FAIL 8n1_busy_after got=%b want=0", busy_a);
    end
  endtask

  task automatic test_7e2();
    push_frame(7, 2, 2, 9'h003);
    send(1, 9'h003, 1'b0);
    check_frames(1, 1, 11, 8, "7e2");
    total++;
    if (busy_b !== 1'b0) begin
      bad++;
      $display("FAIL 7e2_busy_after got=%b want=0", busy_b);
    end
  endtask

  task automatic test_odd_parity();
    push_frame(8, 1, 1, 9'h000);
    send(2, 9'h000, 1'b0);
    check_frames(2, 1, 11, 8, "odd_00");
    push_frame(8, 1, 1, 9'h0FF);
    send(2, 9'h0FF, 1'b0);
    check_frames(2, 1, 11, 8, "odd_ff");
  endtask

  task automatic test_back_to_back();
    logic rdy_log[$];
    logic want[5];
    want = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    push_frame(8, 0, 1, 9'h0A5);
    push_frame(8, 0, 1, 9'h03C);
    fork
      check_frames(0, 2, 10, 8, "b2b");
      begin
        send(0, 9'h0A5, 1'b1);
        send(0, 9'h03C, 1'b0);
      end
      begin
        rdy_log.push_back(if_a.in_ready);
        repeat (120) begin
          @(negedge ref_clk);
          if (if_a.in_ready !== rdy_log[rdy_log.size()-1]) rdy_log.push_back(if_a.in_ready);
        end
      end
    join
    total++;
    if (rdy_log.size() != 5) begin
      bad++;
      $display("FAIL b2b_ready_count got=%0d want=5", rdy_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (rdy_log[i] !== want[i]) begin
          bad++;
          $display("FAIL b2b_ready_%0d got=%b want=%b", i, rdy_log[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_break();
    push_frame(8, 0, 1, 9'h081);
    fork
      check_frames(0, 1, 10, 8, "brk_frame");
      begin
        send(0, 9'h081, 1'b0);
        repeat (20) @(negedge ref_clk);
        brk_a = 1'b1;
        push_frame(8, 0, 1, 9'h05A);
        send(0, 9'h05A, 1'b0);
      end
    join
    for (int i = 0; i < 15; i++) begin
      if (i > 0) wait_bit_edge();
      total++;
      if (out_a !== 1'b0 || busy_a !== 1'b1) begin
        bad++;
        $display("FAIL brk_low_%0d got out/busy=%b%b want 01", i, out_a, busy_a);
      end
    end
    total++;
    if (if_a.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL brk_queued got in_ready=%b want 0", if_a.in_ready);
    end
    @(negedge ref_clk);
    brk_a = 1'b0;
    wait_bit_edge();
    total++;
    if (out_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      bad++;
      $display("FAIL brk_mark got out/busy/done=%b%b%b want 100", out_a, busy_a, done_a);
    end
    check_frames(0, 1, 10, 1, "brk_queued");
  endtask

  task automatic test_reset_midframe();
    int waited;
    send(0, 9'h0F0, 1'b0);
    waited = 0;
    do begin
      wait_bit_edge();
      waited++;
    end while (out_a !== 1'b0 && waited < 8);
    wait_bit_edge();
    wait_bit_edge();
    total++;
    if (out_a !== 1'b0 || busy_a !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre got out/busy=%b%b want 01", out_a, busy_a);
    end
    @(negedge ref_clk);
    #1 reset_n = 1'b0;
    #1;
    total++;
    if ({out_a, busy_a, if_a.in_ready, done_a} !== 4'b1010) begin
      bad++;
      $display("FAIL rst_async got out/busy/rdy/done=%b want 1010", {out_a, busy_a, if_a.in_ready, done_a});
    end
    @(negedge ref_clk);
    reset_n = 1'b1;
    push_frame(8, 0, 1, 9'h012);
    send(0, 9'h012, 1'b0);
    check_frames(0, 1, 10, 8, "after_rst");
  endtask

  initial begin
    set_in(0, 9'h000, 1'b0);
    set_in(1, 9'h000, 1'b0);
    set_in(2, 9'h000, 1'b0);
    test_reset();
    test_8n1();
    test_7e2();
    test_odd_parity();
    test_back_to_back();
    test_break();
    test_reset_midframe();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
